// File: rtl/tv_code_sequencer_if.sv
// Bus between the TV code sequencer, its start/stop source, the code ROM and the IR carrier modulator.
interface tv_code_sequencer_if #(
    parameter int ADDRESS_BITS = 13
);
    logic                    start;
    logic                    stop;
    logic [ADDRESS_BITS-1:0] rom_address;
    logic [7:0]              rom_data;
    logic                    rom_address_overflow;
    logic [7:0]              carrier_div;
    logic                    ir_on;
    logic                    busy;
    logic                    done;
    logic                    table_error;
    logic [15:0]             code_count;

    modport master (
        input  start, stop, rom_data, rom_address_overflow,
        output rom_address, carrier_div, ir_on, busy, done, table_error, code_count
    );

    modport slave (
        output start, stop, rom_data, rom_address_overflow,
        input  rom_address, carrier_div, ir_on, busy, done, table_error, code_count
    );
endinterface

// File: rtl/tv_code_sequencer.sv
// Walks the TV power-code ROM and turns each entry into a timed IR on/off envelope.
// Define TV_SEQ_LOOP_EN to repeat sweeps until stop instead of a single sweep.
module tv_code_sequencer #(
    parameter int ROM_SIZE         = 5320,
    parameter int ADDRESS_BITS     = $clog2(ROM_SIZE),
    parameter int TIME_UNIT_CYCLES = 120,
    parameter int GAP_UNITS        = 25000
) (
    input logic clk,
    input logic rst_n,
    tv_code_sequencer_if.master bus
);
    // state    | meaning
    // IDLE     | waiting for start
    // HDR      | fetch carrier divider (0 / overflow = end of table)
    // CNT      | fetch pair count
    // ON       | fetch on duration
    // OFF      | fetch off duration
    // EMIT_ON  | carrier gated on for on_t units
    // EMIT_OFF | carrier gated off for off_t units
    // GAP      | inter-code silence
    // FIN      | done pulse, back to IDLE

    localparam int UNIT_BITS = (TIME_UNIT_CYCLES > 1) ? $clog2(TIME_UNIT_CYCLES) : 1;
    localparam logic [UNIT_BITS-1:0] UNIT_RELOAD = UNIT_BITS'(TIME_UNIT_CYCLES - 1);
    localparam logic [15:0] GAP_RELOAD = 16'(GAP_UNITS - 1);
    localparam logic [ADDRESS_BITS-1:0] ADDR_MAX =
        (ROM_SIZE >= (1 << ADDRESS_BITS)) ? {ADDRESS_BITS{1'b1}} : ADDRESS_BITS'(ROM_SIZE);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_CNT, S_ON, S_OFF, S_EMIT_ON, S_EMIT_OFF, S_GAP, S_FIN
    } state_t;

`ifdef TV_SEQ_LOOP_EN
    localparam state_t EOT_STATE = S_HDR;
`else
    localparam state_t EOT_STATE = S_FIN;
`endif

    state_t                  state, state_next;
    logic [7:0]              on_t, off_t, pairs_left;
    logic [UNIT_BITS-1:0]    unit_cnt;
    logic [15:0]             dur_cnt;
    logic [ADDRESS_BITS-1:0] rom_address;
    logic [7:0]              carrier_div;
    logic                    ir_on, busy, done, table_error;
    logic [15:0]             code_count;

    logic   eot, timer_tc, abort, fetch, timer_load, pair_end, gap_entry, sweep_start;
    logic   ir_on_d, busy_d, done_d;
    logic [15:0] dur_load;
    state_t pair_next;

    assign eot       = (bus.rom_data == 8'h00) || bus.rom_address_overflow;
    assign timer_tc  = (unit_cnt == '0) && (dur_cnt == 16'd0);
    assign pair_next = (pairs_left == 8'd1) ? S_GAP : S_ON;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (bus.start && !bus.stop) state_next = S_HDR;
            S_HDR:      state_next = eot ? EOT_STATE : S_CNT;
            S_CNT: begin
                if (bus.rom_address_overflow)  state_next = S_FIN;
                else if (bus.rom_data == 8'h00) state_next = S_GAP;
                else                            state_next = S_ON;
            end
            S_ON:       state_next = bus.rom_address_overflow ? S_FIN : S_OFF;
            S_OFF: begin
                // zero durations skip their emit state entirely
                if (bus.rom_address_overflow)   state_next = S_FIN;
                else if (on_t != 8'h00)         state_next = S_EMIT_ON;
                else if (bus.rom_data != 8'h00) state_next = S_EMIT_OFF;
                else                            state_next = pair_next;
            end
            S_EMIT_ON:  if (timer_tc) state_next = (off_t != 8'h00) ? S_EMIT_OFF : pair_next;
            S_EMIT_OFF: if (timer_tc) state_next = pair_next;
            S_GAP:      if (timer_tc) state_next = S_HDR;
            S_FIN:      state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
        if (bus.stop && state != S_IDLE) state_next = S_IDLE;
    end

    always_comb begin
        abort       = bus.stop && (state != S_IDLE);
        sweep_start = (state == S_IDLE) && (state_next == S_HDR);
        fetch       = (state inside {S_HDR, S_CNT, S_ON, S_OFF}) && !abort;
        ir_on_d     = (state_next == S_EMIT_ON);
        busy_d      = (state_next != S_IDLE);
        done_d      = (state_next == S_FIN);
`ifdef TV_SEQ_LOOP_EN
        if ((state == S_HDR) && (state_next == S_HDR)) done_d = 1'b1;
`endif
        timer_load  = (state_next != state) && (state_next inside {S_EMIT_ON, S_EMIT_OFF, S_GAP});
        pair_end    = (state inside {S_OFF, S_EMIT_ON, S_EMIT_OFF}) && (state_next inside {S_ON, S_GAP});
        gap_entry   = (state_next == S_GAP) && (state != S_GAP);
        case (state_next)
            S_EMIT_ON:  dur_load = {8'h00, on_t} - 16'd1;
            S_EMIT_OFF: dur_load = {8'h00, (state == S_OFF) ? bus.rom_data : off_t} - 16'd1;
            S_GAP:      dur_load = GAP_RELOAD;
            default:    dur_load = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_address <= '0;
            carrier_div <= 8'h00;
            ir_on       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            table_error <= 1'b0;
            code_count  <= 16'd0;
            on_t        <= 8'h00;
            off_t       <= 8'h00;
            pairs_left  <= 8'h00;
            unit_cnt    <= '0;
            dur_cnt     <= 16'd0;
        end else begin
            ir_on <= ir_on_d;
            busy  <= busy_d;
            done  <= done_d;

            if (abort || sweep_start)
                rom_address <= '0;
`ifdef TV_SEQ_LOOP_EN
            else if ((state == S_HDR) && (state_next == S_HDR))
                rom_address <= '0;
`endif
            else if (fetch && rom_address != ADDR_MAX)
                rom_address <= rom_address + ADDRESS_BITS'(1);

            if (sweep_start) begin
                table_error <= 1'b0;
                code_count  <= 16'd0;
            end else if (!abort) begin
                if (state == S_HDR && !eot) carrier_div <= bus.rom_data;
                if (state == S_ON)          on_t        <= bus.rom_data;
                if (state == S_OFF)         off_t       <= bus.rom_data;
                if (state == S_CNT)         pairs_left  <= bus.rom_data;
                else if (pair_end)          pairs_left  <= pairs_left - 8'd1;
                if (gap_entry && code_count != 16'hFFFF)
                    code_count <= code_count + 16'd1;
                if ((state inside {S_CNT, S_ON, S_OFF}) && bus.rom_address_overflow)
                    table_error <= 1'b1;
            end

            if (timer_load) begin
                unit_cnt <= UNIT_RELOAD;
                dur_cnt  <= dur_load;
            end else if (state inside {S_EMIT_ON, S_EMIT_OFF, S_GAP}) begin
                if (unit_cnt == '0) begin
                    unit_cnt <= UNIT_RELOAD;
                    dur_cnt  <= dur_cnt - 16'd1;
                end else begin
                    unit_cnt <= unit_cnt - UNIT_BITS'(1);
                end
            end
        end
    end

    assign bus.rom_address = rom_address;
    assign bus.carrier_div = carrier_div;
    assign bus.ir_on       = ir_on;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.table_error = table_error;
    assign bus.code_count  = code_count;
endmodule

// File: tb/tb_tv_code_sequencer.sv
// Scoreboard bench for tv_code_sequencer: a cycle-position reference model of each sweep
// predicts ir_on pulses, done pulses and end-of-sweep state; a negedge monitor checks them.
module tb_tv_code_sequencer;
    localparam int TU       = 4;
    localparam int GAP_U    = 2;
    localparam int ROM_SIZE = 64;
    localparam int AB       = 6;
`ifdef TV_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam int EV_PULSE = 0, EV_DONE = 1, EV_END = 2, EV_IDLE = 3;

    typedef struct {
        int kind; int a; int b; int c; int d; int e;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tv_code_sequencer_if #(.ADDRESS_BITS(AB)) bus ();

    tv_code_sequencer #(
        .ROM_SIZE(ROM_SIZE), .ADDRESS_BITS(AB),
        .TIME_UNIT_CYCLES(TU), .GAP_UNITS(GAP_U)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [7:0] rom [0:ROM_SIZE-1];
    logic [7:0] tbl [$];
    int rom_size;
    assign bus.rom_data = (int'(bus.rom_address) < rom_size) ? rom[bus.rom_address] : 8'h00;
    assign bus.rom_address_overflow = (int'(bus.rom_address) >= rom_size);

    ev_t exp_q [$];
    int  n_checks, n_fail;
    int  last_cdiv;
    bit  mon_en;

    function automatic ev_t mk_ev(int kind, int a, int b, int c, int d, int e);
        ev_t x;
        x.kind = kind; x.a = a; x.b = b; x.c = c; x.d = d; x.e = e;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic observe(input ev_t o);
        ev_t x;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d a=%0d, expected no event", o.kind, o.a);
            return;
        end
        x = exp_q.pop_front();
        check("event_kind", o.kind, x.kind);
        if (o.kind != x.kind) return;
        case (o.kind)
            EV_PULSE: begin
                check("pulse_start", o.a, x.a);
                check("pulse_len", o.b, x.b);
            end
            EV_DONE: check("done_cycle", o.a, x.a);
            EV_END: begin
                check("busy_cycles", o.a, x.a);
                check("code_count", o.b, x.b);
                check("carrier_div", o.c, x.c);
                check("table_error", o.d, x.d);
                if (x.e >= 0) check("rom_address", o.e, x.e);
            end
            default: ;
        endcase
    endtask

    // monitor: measures everything in busy cycles since the sweep began
    int mon_idx, mon_pstart;
    bit prev_busy, prev_ir;
    initial begin
        mon_idx = 0; mon_pstart = 0; prev_busy = 0; prev_ir = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_busy = 0; prev_ir = 0;
            end else begin
                if (bus.busy) begin
                    mon_idx = prev_busy ? mon_idx + 1 : 0;
                    if (bus.ir_on && !prev_ir) mon_pstart = mon_idx;
                    if (!bus.ir_on && prev_ir)
                        observe(mk_ev(EV_PULSE, mon_pstart, mon_idx - mon_pstart, 0, 0, 0));
                    if (bus.done) observe(mk_ev(EV_DONE, mon_idx, 0, 0, 0, 0));
                end else if (prev_busy) begin
                    if (prev_ir)
                        observe(mk_ev(EV_PULSE, mon_pstart, mon_idx + 1 - mon_pstart, 0, 0, 0));
                    observe(mk_ev(EV_END, mon_idx + 1, int'(bus.code_count), int'(bus.carrier_div),
                                  int'(bus.table_error), int'(bus.rom_address)));
                end else if (bus.ir_on || bus.done) begin
                    observe(mk_ev(EV_IDLE, int'(bus.ir_on), int'(bus.done), 0, 0, 0));
                end
                prev_busy = bus.busy;
                prev_ir   = bus.ir_on;
            end
        end
    end

    // Reference model: cycle 0 is the header fetch right after start is taken; a stop
    // sampled at sweep cycle abort_at cancels every effect due at or after that edge.
    task automatic model_run(input int abort_at, input bit do_push, output int blen);
        int c, addr, codes, terr, cdiv, fin_cycle, lim, n, on_u, off_u, len, exp_addr;
        bit halt;
        c = 0; addr = 0; codes = 0; terr = 0; cdiv = last_cdiv; fin_cycle = -1; halt = 0;
        lim = (abort_at > 0) ? abort_at : 32'h3fff_ffff;
        while (!halt && c < lim) begin
            if (addr >= rom_size || rom[addr] == 8'h00) begin
                addr++;
                if (LOOP) begin
                    if (do_push && c + 1 < lim) exp_q.push_back(mk_ev(EV_DONE, c + 1, 0, 0, 0, 0));
                    addr = 0;
                    c++;
                end else begin
                    fin_cycle = c + 1;
                    halt = 1;
                end
                continue;
            end
            if (c + 1 < lim) cdiv = rom[addr];
            addr++; c++;
            if (addr >= rom_size) begin
                addr++; terr = 1; fin_cycle = c + 1; halt = 1;
                continue;
            end
            n = rom[addr]; addr++; c++;
            for (int p = 0; p < n && !halt; p++) begin
                if (addr >= rom_size) begin
                    addr++; terr = 1; fin_cycle = c + 1; halt = 1;
                end else begin
                    on_u = rom[addr]; addr++; c++;
                    if (addr >= rom_size) begin
                        addr++; terr = 1; fin_cycle = c + 1; halt = 1;
                    end else begin
                        off_u = rom[addr]; addr++; c++;
                        if (on_u != 0 && c < lim) begin
                            len = on_u * TU;
                            if (c + len > lim) len = lim - c;
                            if (do_push) exp_q.push_back(mk_ev(EV_PULSE, c, len, 0, 0, 0));
                        end
                        c += (on_u + off_u) * TU;
                    end
                end
            end
            if (!halt) begin
                if (c < lim && codes < 65535) codes++;
                c += GAP_U * TU;
            end
        end
        if (fin_cycle >= 0 && fin_cycle < lim) begin
            if (do_push) exp_q.push_back(mk_ev(EV_DONE, fin_cycle, 0, 0, 0, 0));
            blen = fin_cycle + 1;
        end else begin
            blen = lim;
            terr = 0;
        end
        exp_addr = (abort_at > 0) ? 0 : ((addr > ROM_SIZE - 1) ? ROM_SIZE - 1 : addr);
        if (do_push) begin
            exp_q.push_back(mk_ev(EV_END, blen, codes, cdiv, terr, exp_addr));
            last_cdiv = cdiv;
        end
    endtask

    task automatic load_rom();
        for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'h00;
        for (int i = 0; i < tbl.size(); i++) rom[i] = tbl[i];
        rom_size = tbl.size();
    endtask

    task automatic gen_rand_table();
        int ncodes, np;
        tbl.delete();
        ncodes = $urandom_range(1, 3);
        for (int k = 0; k < ncodes; k++) begin
            tbl.push_back(8'($urandom_range(1, 255)));
            np = $urandom_range(0, 3);
            tbl.push_back(8'(np));
            for (int p = 0; p < np; p++) begin
                tbl.push_back(8'($urandom_range(0, 3)));
                tbl.push_back(8'($urandom_range(0, 3)));
            end
        end
        tbl.push_back(8'h00);
        load_rom();
        if ($urandom_range(0, 3) == 0) rom_size = $urandom_range(1, tbl.size() - 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("sweep_finished_busy", int'(bus.busy), 0);
    endtask

    task automatic run_seq(input int abort_at, input int extra_start);
        int blen;
        model_run(abort_at, 1'b1, blen);
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clk);
            #1 bus.stop = 1'b1;
            @(posedge clk); #1 bus.stop = 1'b0;
        end else if (extra_start > 0) begin
            repeat (extra_start - 1) @(posedge clk);
            #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
        end
        wait_idle(20000);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ir_on"}, int'(bus.ir_on), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_table_error"}, int'(bus.table_error), 0);
        check({tag, "_code_count"}, int'(bus.code_count), 0);
        check({tag, "_carrier_div"}, int'(bus.carrier_div), 0);
        check({tag, "_rom_address"}, int'(bus.rom_address), 0);
    endtask

    initial begin
        int blen, ab;
        n_checks = 0; n_fail = 0; last_cdiv = 0; mon_en = 0; rom_size = 0;
        bus.start = 1'b0; bus.stop = 1'b0;
        for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;

`ifdef TV_SEQ_LOOP_EN
        tbl = '{8'h1A, 8'h01, 8'h03, 8'h02, 8'h00};
        load_rom();
        run_seq(70, 0);
`else
        tbl = '{8'h1A, 8'h01, 8'h03, 8'h02, 8'h00};
        load_rom();
        run_seq(0, 0);

        tbl = '{8'h10, 8'h02, 8'h00, 8'h05, 8'h04, 8'h00, 8'h22, 8'h00, 8'h00};
        load_rom();
        run_seq(0, 0);

        tbl = '{8'h10, 8'h05, 8'h02};
        load_rom();
        run_seq(0, 0);

        tbl = '{8'h1A, 8'h01, 8'h03, 8'h02, 8'h00};
        load_rom();
        run_seq(7, 0);
        run_seq(0, 10);

        for (int r = 0; r < 24; r++) begin
            gen_rand_table();
            model_run(0, 1'b0, blen);
            ab = 0;
            if ($urandom_range(0, 2) == 0 && blen > 1) ab = $urandom_range(1, blen - 1);
            run_seq(ab, 0);
        end
`endif

        // start and stop together while idle: must not launch a sweep
        @(posedge clk); #1 bus.start = 1'b1; bus.stop = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0; bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("start_stop_idle_busy", int'(bus.busy), 0);
        end

        // reset in the middle of the first on-envelope
        mon_en = 0;
        tbl = '{8'h1A, 8'h01, 8'h03, 8'h02, 8'h00};
        load_rom();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 check("pre_reset_ir_on", int'(bus.ir_on), 1);
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        #10 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        check("leftover_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
